// File: rtl/panel_status_transmitter.sv
// Uplink status reporter: turns changed control-state fields into decoder opcode bytes on a UART TX handshake.
// Define PANEL_TX_HEARTBEAT_EN to force a full resend every HEARTBEAT_CYCLES clocks.
`ifndef PERSON_COUNTER_DATA_WIDTH
`define PERSON_COUNTER_DATA_WIDTH 8
`endif

module panel_status_transmitter #(
  parameter int COUNT_W          = `PERSON_COUNTER_DATA_WIDTH,
  parameter int HEARTBEAT_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               emergency_active,
  input  logic               eco_mode,
  input  logic               security_armed,
  input  logic [1:0]         ac_mode,
  input  logic [COUNT_W-1:0] person_count,
  input  logic               sync_req,
  input  logic               tx_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  output logic               pending
);

  typedef enum logic {S_IDLE, S_SEND} state_t;
  typedef enum logic [2:0] {F_EMERG = 3'd0, F_SEC = 3'd1, F_ECO = 3'd2, F_AC = 3'd3, F_COUNT = 3'd4} field_t;

  localparam logic [COUNT_W-1:0] POS_LIM = COUNT_W'(7);
  localparam logic [COUNT_W-1:0] NEG_LIM = COUNT_W'(-8);

  state_t             state_reg, state_next;
  field_t             field_reg, field_next;
  logic [7:0]         data_reg, data_next;
  logic [4:0]         force_reg, force_next;
  logic               shadow_emerg_reg, shadow_sec_reg, shadow_eco_reg;
  logic [1:0]         shadow_ac_reg;
  logic [COUNT_W-1:0] shadow_count_reg;

  logic [4:0]         dirty;
  logic [COUNT_W-1:0] diff;
  logic [COUNT_W-1:0] payload_ext;
  logic [3:0]         delta;
  logic               accept;
  logic               resync;

`ifdef PANEL_TX_HEARTBEAT_EN
  localparam int HB_W = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;

  logic [HB_W-1:0] hb_reg;
  logic            hb_wrap;

  assign hb_wrap = (hb_reg == HB_W'(HEARTBEAT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       hb_reg <= '0;
    else if (hb_wrap) hb_reg <= '0;
    else              hb_reg <= hb_reg + HB_W'(1);
  end

  assign resync = sync_req | hb_wrap;
`else
  assign resync = sync_req;
`endif

  // Difference wraps modulo 2^COUNT_W and is read as signed, then clamped to a 4-bit step.
  assign diff = person_count - shadow_count_reg;

  always_comb begin
    if ($signed(diff) > $signed(POS_LIM))      delta = 4'h7;
    else if ($signed(diff) < $signed(NEG_LIM)) delta = 4'h8;
    else                                       delta = diff[3:0];
  end

  // Shadow count advances by the step that was actually sent, so large jumps converge over several bytes.
  always_comb begin
    payload_ext      = {COUNT_W{data_reg[3]}};
    payload_ext[3:0] = data_reg[3:0];
  end

  assign dirty[F_EMERG] = (emergency_active != shadow_emerg_reg) | force_reg[F_EMERG];
  assign dirty[F_SEC]   = (security_armed   != shadow_sec_reg)   | force_reg[F_SEC];
  assign dirty[F_ECO]   = (eco_mode         != shadow_eco_reg)   | force_reg[F_ECO];
  assign dirty[F_AC]    = (ac_mode          != shadow_ac_reg)    | force_reg[F_AC];
  assign dirty[F_COUNT] = (person_count     != shadow_count_reg) | force_reg[F_COUNT];

  assign pending = (|dirty) | (state_reg == S_SEND);
  assign tx_data = data_reg;

  always_comb begin
    state_next = state_reg;
    field_next = field_reg;
    data_next  = data_reg;
    tx_valid   = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (|dirty) begin
          state_next = S_SEND;
          if (dirty[F_EMERG]) begin
            field_next = F_EMERG;
            data_next  = {7'b0001000, emergency_active};
          end else if (dirty[F_SEC]) begin
            field_next = F_SEC;
            data_next  = {7'b0111000, security_armed};
          end else if (dirty[F_ECO]) begin
            field_next = F_ECO;
            data_next  = {7'b0000000, eco_mode};
          end else if (dirty[F_AC]) begin
            field_next = F_AC;
            data_next  = {6'b101000, ac_mode};
          end else begin
            field_next = F_COUNT;
            data_next  = {4'hC, delta};
          end
        end
      end
      S_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          accept     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A resync arriving while a byte is accepted re-arms that field too, since it postdates the latch.
  always_comb begin
    force_next = force_reg;
    if (accept) force_next[field_reg] = 1'b0;
    if (resync) force_next = 5'b11111;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= S_IDLE;
      field_reg        <= F_EMERG;
      data_reg         <= 8'h00;
      force_reg        <= 5'b00000;
      shadow_emerg_reg <= 1'b0;
      shadow_sec_reg   <= 1'b0;
      shadow_eco_reg   <= 1'b0;
      shadow_ac_reg    <= 2'b00;
      shadow_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      field_reg <= field_next;
      data_reg  <= data_next;
      force_reg <= force_next;
      if (accept) begin
        case (field_reg)
          F_EMERG: shadow_emerg_reg <= data_reg[0];
          F_SEC:   shadow_sec_reg   <= data_reg[0];
          F_ECO:   shadow_eco_reg   <= data_reg[0];
          F_AC:    shadow_ac_reg    <= data_reg[1:0];
          F_COUNT: shadow_count_reg <= shadow_count_reg + payload_ext;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_panel_status_transmitter.sv
// Self-checking bench for panel_status_transmitter: expected bytes are queued as stimulus is applied
// and matched against bytes the monitor captures on each accepted handshake.
module tb_panel_status_transmitter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       emergency_active = 1'b0;
  logic       eco_mode = 1'b0;
  logic       security_armed = 1'b0;
  logic [1:0] ac_mode = 2'b00;
  logic [7:0] person_count = 8'd0;
  logic       sync_req = 1'b0;
  logic       tx_ready = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       pending;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_t[$];

  always #5 clk = ~clk;

  panel_status_transmitter #(
    .COUNT_W(8),
    .HEARTBEAT_CYCLES(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .emergency_active(emergency_active),
    .eco_mode(eco_mode),
    .security_armed(security_armed),
    .ac_mode(ac_mode),
    .person_count(person_count),
    .sync_req(sync_req),
    .tx_ready(tx_ready),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .pending(pending)
  );

  // Monitor: record every byte that will be accepted at the coming rising edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      obs_q.push_back(tx_data);
      obs_t.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_obs(input int budget, output bit got);
    int n = 0;
    while (obs_q.size() <= rd && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    got = (obs_q.size() > rd);
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%02h pending=%b, expected 0/00/0", tx_valid, tx_data, pending);
    end
    reset = 1'b1;
    tx_ready = 1'b1;
`ifndef PANEL_TX_HEARTBEAT_EN
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (tx_valid !== 1'b0 || pending !== 1'b0) begin
        errors++;
        $display("FAIL reset_quiet: cycle %0d valid=%b pending=%b, expected 0/0", i, tx_valid, pending);
      end
    end
    $display("reset: quiet for 100 cycles");
`endif
  endtask

  task automatic test_emergency();
    logic [7:0] e;
    bit got;
    emergency_active = 1'b1;
    exp_q.push_back(8'h11);
    step();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin
      errors++;
      $display("FAIL emerg_latency: valid=%b data=%02h, expected 1/11", tx_valid, tx_data);
    end
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        emergency_active = 1'b0;
        exp_q.push_back(8'h10);
      end
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        wait_obs(100, got);
        checks++;
        if (!got) begin
          errors++;
          $display("FAIL emerg_byte: no byte, expected %02h", e);
        end else begin
          if (obs_q[rd] !== e) begin
            errors++;
            $display("FAIL emerg_byte: got %02h expected %02h", obs_q[rd], e);
          end else $display("emerg_byte: %02h at cycle %0d", obs_q[rd], obs_t[rd]);
          rd++;
        end
      end
      repeat (10) step();
      checks++;
      if (obs_q.size() != rd) begin
        errors++;
        $display("FAIL emerg_idle: %0d extra bytes, expected 0", obs_q.size() - rd);
        rd = obs_q.size();
      end
    end
  endtask

  task automatic test_count();
    logic [7:0] e;
    bit got;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        person_count = 8'd20;
        exp_q.push_back(8'hC7);
        exp_q.push_back(8'hC7);
        exp_q.push_back(8'hC6);
      end else begin
        person_count = 8'd15;
        exp_q.push_back(8'hCB);
      end
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        wait_obs(100, got);
        checks++;
        if (!got) begin
          errors++;
          $display("FAIL count_byte: no byte, expected %02h", e);
        end else begin
          if (obs_q[rd] !== e) begin
            errors++;
            $display("FAIL count_byte: got %02h expected %02h", obs_q[rd], e);
          end else $display("count_byte: %02h at cycle %0d", obs_q[rd], obs_t[rd]);
          rd++;
        end
      end
      repeat (10) step();
      checks++;
      if (obs_q.size() != rd) begin
        errors++;
        $display("FAIL count_idle: %0d extra bytes, expected 0", obs_q.size() - rd);
        rd = obs_q.size();
      end
    end
  endtask

  task automatic test_latch_window();
    logic [7:0] e;
    bit got;
    // Change after latch: 0x11 is frozen, the release is sent afterwards.
    tx_ready = 1'b0;
    emergency_active = 1'b1;
    step();
    step();
    emergency_active = 1'b0;
    step();
    tx_ready = 1'b1;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h10);
    // Glitch before latch: eco toggles while security is stalled and must never be sent.
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        tx_ready = 1'b0;
        security_armed = 1'b1;
        step();
        step();
        eco_mode = 1'b1;
        step();
        eco_mode = 1'b0;
        step();
        tx_ready = 1'b1;
        exp_q.push_back(8'h71);
      end
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        wait_obs(100, got);
        checks++;
        if (!got) begin
          errors++;
          $display("FAIL latch_byte: no byte, expected %02h", e);
        end else begin
          if (obs_q[rd] !== e) begin
            errors++;
            $display("FAIL latch_byte: got %02h expected %02h", obs_q[rd], e);
          end else $display("latch_byte: %02h at cycle %0d", obs_q[rd], obs_t[rd]);
          rd++;
        end
      end
      repeat (10) step();
      checks++;
      if (obs_q.size() != rd) begin
        errors++;
        $display("FAIL latch_idle: %0d extra bytes, expected 0", obs_q.size() - rd);
        rd = obs_q.size();
      end
    end
    security_armed = 1'b0;
    exp_q.push_back(8'h70);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      wait_obs(100, got);
      checks++;
      if (!got || obs_q[rd] !== e) begin
        errors++;
        $display("FAIL latch_restore: got %02h expected %02h", got ? obs_q[rd] : 8'h00, e);
      end else $display("latch_byte: %02h at cycle %0d", obs_q[rd], obs_t[rd]);
      if (got) rd++;
    end
  endtask

  task automatic test_priority_stall();
    logic [7:0] e;
    bit got;
    tx_ready = 1'b0;
    eco_mode = 1'b1;
    security_armed = 1'b1;
    ac_mode = 2'd2;
    exp_q.push_back(8'h71);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hA2);
    step();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h71) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d valid=%b data=%02h, expected 1/71", i, tx_valid, tx_data);
      end
      step();
    end
    tx_ready = 1'b1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      wait_obs(100, got);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL prio_byte: no byte, expected %02h", e);
      end else begin
        if (obs_q[rd] !== e) begin
          errors++;
          $display("FAIL prio_byte: got %02h expected %02h", obs_q[rd], e);
        end else $display("prio_byte: %02h at cycle %0d", obs_q[rd], obs_t[rd]);
        rd++;
      end
    end
    repeat (10) step();
    checks++;
    if (obs_q.size() != rd) begin
      errors++;
      $display("FAIL prio_idle: %0d extra bytes, expected 0", obs_q.size() - rd);
      rd = obs_q.size();
    end
  endtask

  task automatic test_sync_and_reset();
    logic [7:0] e;
    bit got;
    int n;
    // Settle to emergency=1, count=20 with everything else cleared.
    emergency_active = 1'b1;
    person_count = 8'd20;
    security_armed = 1'b0;
    eco_mode = 1'b0;
    ac_mode = 2'd0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h70);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hC5);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h70);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hC0);
      end
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        wait_obs(100, got);
        checks++;
        if (!got) begin
          errors++;
          $display("FAIL sync_byte: no byte, expected %02h", e);
        end else begin
          if (obs_q[rd] !== e) begin
            errors++;
            $display("FAIL sync_byte: got %02h expected %02h", obs_q[rd], e);
          end else $display("sync_byte: %02h at cycle %0d", obs_q[rd], obs_t[rd]);
          rd++;
        end
      end
      repeat (10) step();
      checks++;
      if (obs_q.size() != rd) begin
        errors++;
        $display("FAIL sync_idle: %0d extra bytes, expected 0", obs_q.size() - rd);
        rd = obs_q.size();
      end
    end
    // Reset mid-stream: hold the first resync byte, then assert reset between edges.
    tx_ready = 1'b0;
    sync_req = 1'b1;
    step();
    sync_req = 1'b0;
    n = 0;
    while (tx_valid !== 1'b1 && n < 5) begin
      step();
      n++;
    end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin
      errors++;
      $display("FAIL midstream_valid: valid=%b data=%02h, expected 1/11", tx_valid, tx_data);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%02h, expected 0/00", tx_valid, tx_data);
    end else $display("async_reset: tx_valid dropped without a clock edge");
    emergency_active = 1'b0;
    person_count = 8'd0;
    step();
    reset = 1'b1;
    tx_ready = 1'b1;
    step();
    checks++;
    if (tx_valid !== 1'b0 || pending !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: valid=%b pending=%b, expected 0/0", tx_valid, pending);
    end
  endtask

  task automatic test_heartbeat();
    logic [7:0] e;
    bit got;
    int start[3];
`ifdef PANEL_TX_HEARTBEAT_EN
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back(8'h10);
      exp_q.push_back(8'h70);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hA0);
      exp_q.push_back(8'hC0);
      start[f] = rd;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        wait_obs(100, got);
        checks++;
        if (!got) begin
          errors++;
          $display("FAIL hb_byte: no byte, expected %02h", e);
        end else begin
          if (obs_q[rd] !== e) begin
            errors++;
            $display("FAIL hb_byte: got %02h expected %02h", obs_q[rd], e);
          end else $display("hb_byte: %02h at cycle %0d", obs_q[rd], obs_t[rd]);
          rd++;
        end
      end
    end
    for (int f = 1; f < 3; f++) begin
      checks++;
      if (rd < 15 || obs_t[start[f]] - obs_t[start[f-1]] != 64) begin
        errors++;
        $display("FAIL hb_period: frame %0d spacing %0d, expected 64", f,
                 (rd < 15) ? -1 : obs_t[start[f]] - obs_t[start[f-1]]);
      end
    end
`else
    start[0] = rd;
    repeat (200) step();
    checks++;
    if (obs_q.size() != start[0] || pending !== 1'b0) begin
      errors++;
      $display("FAIL hb_off: %0d bytes pending=%b, expected 0/0", obs_q.size() - start[0], pending);
    end else $display("hb_off: no traffic in 200 cycles");
    e = 8'h00;
    got = 1'b0;
    start[1] = 0;
    start[2] = 0;
`endif
  endtask

  initial begin
    test_reset();
`ifndef PANEL_TX_HEARTBEAT_EN
    test_emergency();
    test_count();
    test_latch_window();
    test_priority_stall();
    test_sync_and_reset();
`endif
    test_heartbeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
